// File: rtl/fc_seq_ctrl.sv
// fc_seq_ctrl: sequencing controller for one fully-connected layer.
//   Loads an N-element x vector, then walks the M/P output groups. For each
//   group it issues N x/weight addresses, drives the lane accumulator
//   controls, and then drains the P lane results one at a time.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   input_valid / input_ready   x element stream (accepted only in LOAD)
//   output_valid / output_ready result stream, lane chosen by one-hot f_sel
//   addr_x, wr_en_x             x memory address / write enable
//   addr_w, wr_en_w             weight ROM address (g*N+j) / write enable (0)
//   clear_acc, en_acc           lane accumulator clear / accumulate
//   f_sel                       one-hot lane select for the output mux
//   layer_done                  one-cycle pulse after the last result
module fc_seq_ctrl #(
  parameter int M       = 16,
  parameter int N       = 8,
  parameter int T       = 16,
  parameter int P       = 8,
  parameter int MAC_LAT = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       input_valid,
  output logic                       input_ready,
  input  logic                       output_ready,
  output logic                       output_valid,
  output logic [$clog2(N)-1:0]       addr_x,
  output logic                       wr_en_x,
  output logic [$clog2(M*N/P)-1:0]   addr_w,
  output logic                       wr_en_w,
  output logic                       clear_acc,
  output logic                       en_acc,
  output logic [P-1:0]               f_sel,
  output logic                       layer_done
);

  localparam int XW = $clog2(N);
  localparam int WW = $clog2(M*N/P);
  localparam int G  = M / P;
  localparam int GW = (G > 1) ? $clog2(G) : 1;
  localparam int LW = (P > 1) ? $clog2(P) : 1;
  localparam int CW = $clog2(MAC_LAT + 1);

  // Elaboration-time parameter sanity.
  if (T < 1 || MAC_LAT < 1 || N < 2 || (M % P) != 0) begin : g_bad_param
    $error("fc_seq_ctrl: illegal parameter set");
  end

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_WAIT    = 2'd2,
    ST_OUTPUT  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [XW-1:0]   k_q, k_d;
  logic [XW-1:0]   j_q, j_d;
  logic [GW-1:0]   g_q, g_d;
  logic [LW-1:0]   lane_q, lane_d;
  logic [CW-1:0]   wcnt_q, wcnt_d;
  logic            done_q, done_d;
  logic [XW-1:0]   addr_x_q;
  logic [WW-1:0]   addr_w_q;

  // Issue-valid delay line; stage MAC_LAT lines up with the MAC result.
  logic               issue;
  logic [MAC_LAT:1]   vld_pipe_q;

  logic [WW-1:0]   addr_w_calc;
  assign addr_w_calc = WW'(g_q) * WW'(N) + WW'(j_q);
  assign wr_en_w     = 1'b0;

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    j_d          = j_q;
    g_d          = g_q;
    lane_d       = lane_q;
    wcnt_d       = wcnt_q;
    done_d       = 1'b0;
    issue        = 1'b0;
    input_ready  = 1'b0;
    output_valid = 1'b0;
    wr_en_x      = 1'b0;
    clear_acc    = 1'b0;
    f_sel        = '0;
    // Addresses hold their last driven value outside the states that use them.
    addr_x       = addr_x_q;
    addr_w       = addr_w_q;

    unique case (state_q)
      ST_LOAD: begin
        input_ready = 1'b1;
        wr_en_x     = input_valid;
        addr_x      = k_q;
        if (input_valid) begin
          if (k_q == XW'(N-1)) begin
            k_d     = '0;
            j_d     = '0;
            g_d     = '0;
            state_d = ST_COMPUTE;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      ST_COMPUTE: begin
        addr_x    = j_q;
        addr_w    = addr_w_calc;
        issue     = 1'b1;
        clear_acc = (j_q == '0);
        if (j_q == XW'(N-1)) begin
          j_d     = '0;
          wcnt_d  = '0;
          state_d = ST_WAIT;
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      ST_WAIT: begin
        // Let the trailing en_acc pulses retire before reading lanes out.
        if (wcnt_q == CW'(MAC_LAT-1)) begin
          wcnt_d  = '0;
          lane_d  = '0;
          state_d = ST_OUTPUT;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      ST_OUTPUT: begin
        output_valid = 1'b1;
        f_sel        = P'(1) << lane_q;
        if (output_ready) begin
          if (lane_q == LW'(P-1)) begin
            lane_d = '0;
            if (g_q != GW'(G-1)) begin
              g_d     = g_q + 1'b1;
              j_d     = '0;
              state_d = ST_COMPUTE;
            end else begin
              done_d  = 1'b1;
              state_d = ST_LOAD;
            end
          end else begin
            lane_d = lane_q + 1'b1;
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase

    // Outputs are forced quiet while reset is held, whatever the state.
    if (reset) begin
      input_ready  = 1'b0;
      output_valid = 1'b0;
      wr_en_x      = 1'b0;
      clear_acc    = 1'b0;
      f_sel        = '0;
      addr_x       = '0;
      addr_w       = '0;
    end
  end

  assign en_acc     = vld_pipe_q[MAC_LAT] & ~reset;
  assign layer_done = done_q & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_LOAD;
      k_q        <= '0;
      j_q        <= '0;
      g_q        <= '0;
      lane_q     <= '0;
      wcnt_q     <= '0;
      done_q     <= 1'b0;
      addr_x_q   <= '0;
      addr_w_q   <= '0;
      vld_pipe_q <= '0;
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      j_q           <= j_d;
      g_q           <= g_d;
      lane_q        <= lane_d;
      wcnt_q        <= wcnt_d;
      done_q        <= done_d;
      addr_x_q      <= addr_x;
      addr_w_q      <= addr_w;
      vld_pipe_q[1] <= issue;
      for (int i = 2; i <= MAC_LAT; i++) vld_pipe_q[i] <= vld_pipe_q[i-1];
    end
  end

endmodule

// File: tb/tb_fc_seq_ctrl.sv
// Directed bench for fc_seq_ctrl with default parameters (M=16 N=8 P=8 MAC_LAT=2).
module tb_fc_seq_ctrl;
  logic        clk;
  logic        reset;
  logic        input_valid;
  logic        input_ready;
  logic        output_ready;
  logic        output_valid;
  logic [2:0]  addr_x;
  logic        wr_en_x;
  logic [3:0]  addr_w;
  logic        wr_en_w;
  logic        clear_acc;
  logic        en_acc;
  logic [7:0]  f_sel;
  logic        layer_done;

  int n_chk  = 0;
  int n_pass = 0;

  fc_seq_ctrl #(.M(16), .N(8), .T(16), .P(8), .MAC_LAT(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .input_valid  (input_valid),
    .input_ready  (input_ready),
    .output_ready (output_ready),
    .output_valid (output_valid),
    .addr_x       (addr_x),
    .wr_en_x      (wr_en_x),
    .addr_w       (addr_w),
    .wr_en_w      (wr_en_w),
    .clear_acc    (clear_acc),
    .en_acc       (en_acc),
    .f_sel        (f_sel),
    .layer_done   (layer_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] all_outs;
  assign all_outs = {10'd0, input_ready, output_valid, wr_en_x, wr_en_w, clear_acc,
                     en_acc, layer_done, f_sel, addr_x, addr_w};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset        = 1'b1;
    input_valid  = 1'b1;
    output_ready = 1'b1;

    // Reset: every output low even with input_valid high.
    tick(); settle();
    chk("rst_outs0", all_outs, 0);
    tick(); settle();
    chk("rst_outs1", all_outs, 0);

    // Load with input_valid held high.
    reset = 1'b0;
    settle();
    for (int i = 0; i < 8; i++) begin
      chk("ld_ready", input_ready, 1);
      chk("ld_wr", wr_en_x, 1);
      chk("ld_addr", addr_x, i);
      tick();
    end
    input_valid = 1'b0;
    settle();

    // Group 0 compute.
    for (int j = 0; j < 8; j++) begin
      chk("c0_ready", input_ready, 0);
      chk("c0_wr", wr_en_x, 0);
      chk("c0_addr_x", addr_x, j);
      chk("c0_addr_w", addr_w, j);
      chk("c0_clear", clear_acc, (j == 0) ? 1 : 0);
      chk("c0_en", en_acc, (j >= 2) ? 1 : 0);
      chk("c0_oval", output_valid, 0);
      tick();
    end
    for (int w = 0; w < 2; w++) begin
      chk("w0_en", en_acc, 1);
      chk("w0_oval", output_valid, 0);
      chk("w0_clear", clear_acc, 0);
      tick();
    end

    // Group 0 drain, with 5 cycles of backpressure on lane 3.
    for (int l = 0; l < 8; l++) begin
      if (l == 3) begin
        output_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          settle();
          chk("bp_fsel", f_sel, 8'h08);
          chk("bp_oval", output_valid, 1);
          tick();
        end
        output_ready = 1'b1;
      end
      settle();
      chk("o0_oval", output_valid, 1);
      chk("o0_fsel", f_sel, 32'd1 << l);
      chk("o0_en", en_acc, 0);
      chk("o0_done", layer_done, 0);
      tick();
    end

    // Group 1 compute: weights 8..15.
    for (int j = 0; j < 8; j++) begin
      chk("c1_addr_w", addr_w, 8 + j);
      chk("c1_clear", clear_acc, (j == 0) ? 1 : 0);
      chk("c1_en", en_acc, (j >= 2) ? 1 : 0);
      tick();
    end
    for (int w = 0; w < 2; w++) begin
      chk("w1_en", en_acc, 1);
      tick();
    end
    for (int l = 0; l < 8; l++) begin
      chk("o1_fsel", f_sel, 32'd1 << l);
      chk("o1_done", layer_done, 0);
      tick();
    end

    // Layer complete.
    chk("done_pulse", layer_done, 1);
    chk("done_ready", input_ready, 1);
    chk("done_oval", output_valid, 0);
    chk("done_fsel", f_sel, 0);
    tick();
    chk("done_clr", layer_done, 0);

    // Load with alternating input_valid.
    for (int c = 0; c < 15; c++) begin
      input_valid = (c % 2 == 0);
      settle();
      chk("gap_ready", input_ready, 1);
      chk("gap_wr", wr_en_x, (c % 2 == 0) ? 1 : 0);
      chk("gap_addr", addr_x, (c + 1) / 2);
      tick();
    end
    input_valid = 1'b0;
    settle();
    chk("gap_to_comp_ready", input_ready, 0);
    chk("gap_to_comp_clear", clear_acc, 1);

    // Reset in the middle of COMPUTE at j=4.
    for (int j = 0; j < 4; j++) tick();
    chk("mid_addr_x", addr_x, 4);
    chk("mid_en", en_acc, 1);
    reset = 1'b1;
    settle();
    chk("mid_rst_outs0", all_outs, 0);
    tick(); settle();
    chk("mid_rst_outs1", all_outs, 0);
    reset = 1'b0;
    settle();
    chk("post_rst_ready", input_ready, 1);
    chk("post_rst_addr", addr_x, 0);
    chk("post_rst_en", en_acc, 0);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("post_rst_noen", en_acc, 0);
      chk("post_rst_nowr", wr_en_x, 0);
      chk("post_rst_nclr", clear_acc, 0);
    end

    // Fresh load after the mid-operation reset.
    input_valid = 1'b1;
    settle();
    for (int i = 0; i < 8; i++) begin
      chk("rl_addr", addr_x, i);
      chk("rl_wr", wr_en_x, 1);
      tick();
    end
    input_valid = 1'b0;
    settle();
    chk("rl_comp_clear", clear_acc, 1);
    chk("rl_comp_addr_w", addr_w, 0);
    chk("rl_comp_ready", input_ready, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
